// File: rtl/heater_key_ctrl.sv
// Heater key controller: maps scanner key pulses to power, mode and setpoint.
// Define KEY_BEEP_EN to build the key-acknowledge beep counter.
module heater_key_ctrl #(
    parameter int T_MIN       = 30,
    parameter int T_MAX       = 75,
    parameter int T_DEFAULT   = 40,
    parameter int TIMEOUT_CYC = 250000000,
    parameter int CNT_W       = 28,
    parameter int BEEP_CYC    = 5000000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [15:0] pulse,
    output logic        power_on,
    output logic [1:0]  mode,
    output logic [6:0]  setpoint,
    output logic        edit_active,
    output logic [6:0]  edit_val,
    output logic [1:0]  digit_cnt,
    output logic        sp_upd,
    output logic        err_pulse,
    output logic        beep
);

    typedef enum logic [1:0] {
        S_OFF,
        S_RUN,
        S_EDIT
    } state_t;

    localparam logic [6:0] SP_MIN = 7'(T_MIN);
    localparam logic [6:0] SP_MAX = 7'(T_MAX);
    localparam logic [6:0] SP_DEF = 7'(T_DEFAULT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [3:0] K_UP    = 4'hA;
    localparam logic [3:0] K_DOWN  = 4'hB;
    localparam logic [3:0] K_CLEAR = 4'hC;
    localparam logic [3:0] K_ENTER = 4'hD;
    localparam logic [3:0] K_MODE  = 4'hE;
    localparam logic [3:0] K_POWER = 4'hF;

    state_t           state, state_nx;
    logic             pwr_nx;
    logic [1:0]       mode_nx;
    logic [6:0]       sp_nx;
    logic [6:0]       ev_nx;
    logic [1:0]       dc_nx;
    logic             upd_nx;
    logic             err_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic       key_vld;
    logic [3:0] key;
    logic       is_dig;
    logic [6:0] dig;
    logic [6:0] ev_ext;
    logic       ev_in_rng;

    // Highest set index wins when several keys arrive together.
    always_comb begin
        key = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pulse[i]) key = 4'(i);
        end
    end

    assign key_vld   = |pulse;
    assign is_dig    = key < 4'd10;
    assign dig       = {3'b000, key};
    assign ev_ext    = {edit_val[3:0], 3'b000} + {edit_val[5:0], 1'b0} + dig;
    assign ev_in_rng = (edit_val >= SP_MIN) && (edit_val <= SP_MAX);

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state     <= S_OFF;
            power_on  <= 1'b0;
            mode      <= 2'd0;
            setpoint  <= SP_DEF;
            edit_val  <= 7'd0;
            digit_cnt <= 2'd0;
            sp_upd    <= 1'b0;
            err_pulse <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_nx;
            power_on  <= pwr_nx;
            mode      <= mode_nx;
            setpoint  <= sp_nx;
            edit_val  <= ev_nx;
            digit_cnt <= dc_nx;
            sp_upd    <= upd_nx;
            err_pulse <= err_nx;
            cnt       <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pwr_nx   = power_on;
        mode_nx  = mode;
        sp_nx    = setpoint;
        ev_nx    = edit_val;
        dc_nx    = digit_cnt;
        upd_nx   = 1'b0;
        err_nx   = 1'b0;
        cnt_nx   = '0;
        case (state)
            S_OFF: begin
                if (key_vld && key == K_POWER) begin
                    pwr_nx   = 1'b1;
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (key_vld) begin
                    case (key)
                        K_POWER: begin
                            pwr_nx   = 1'b0;
                            state_nx = S_OFF;
                        end
                        K_UP: begin
                            if (setpoint >= SP_MAX) begin
                                err_nx = 1'b1;
                            end else begin
                                sp_nx  = setpoint + 7'd1;
                                upd_nx = 1'b1;
                            end
                        end
                        K_DOWN: begin
                            if (setpoint <= SP_MIN) begin
                                err_nx = 1'b1;
                            end else begin
                                sp_nx  = setpoint - 7'd1;
                                upd_nx = 1'b1;
                            end
                        end
                        K_MODE: mode_nx = (mode == 2'd2) ? 2'd0 : mode + 2'd1;
                        default: begin
                            if (is_dig) begin
                                state_nx = S_EDIT;
                                ev_nx    = dig;
                                dc_nx    = 2'd1;
                            end
                        end
                    endcase
                end
            end
            S_EDIT: begin
                if (key_vld) begin
                    case (key)
                        K_ENTER: begin
                            if (digit_cnt == 2'd0) begin
                                state_nx = S_RUN;
                            end else if (ev_in_rng) begin
                                sp_nx    = edit_val;
                                upd_nx   = edit_val != setpoint;
                                ev_nx    = 7'd0;
                                dc_nx    = 2'd0;
                                state_nx = S_RUN;
                            end else begin
                                err_nx = 1'b1;
                                ev_nx  = 7'd0;
                                dc_nx  = 2'd0;
                            end
                        end
                        K_CLEAR: begin
                            ev_nx = 7'd0;
                            dc_nx = 2'd0;
                            if (digit_cnt == 2'd0) state_nx = S_RUN;
                        end
                        K_POWER: begin
                            pwr_nx   = 1'b0;
                            ev_nx    = 7'd0;
                            dc_nx    = 2'd0;
                            state_nx = S_OFF;
                        end
                        default: begin
                            if (is_dig) begin
                                if (digit_cnt == 2'd2) begin
                                    err_nx = 1'b1;
                                end else begin
                                    ev_nx = ev_ext;
                                    dc_nx = digit_cnt + 2'd1;
                                end
                            end
                        end
                    endcase
                end else if (cnt == CNT_LAST) begin
                    ev_nx    = 7'd0;
                    dc_nx    = 2'd0;
                    state_nx = S_RUN;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = S_OFF;
        endcase
    end

    always_comb begin
        edit_active = (state == S_EDIT);
    end

`ifdef KEY_BEEP_EN
    localparam int BW = $clog2(3 * BEEP_CYC + 1);

    logic [BW-1:0] beep_cnt;
    logic          chg;

    assign chg = key_vld && ((state_nx != state) || (pwr_nx != power_on) ||
                             (mode_nx != mode) || (sp_nx != setpoint) ||
                             (ev_nx != edit_val) || (dc_nx != digit_cnt));

    // A rejected key gets a triple-length beep.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            beep_cnt <= '0;
        end else if (err_nx) begin
            beep_cnt <= BW'(3 * BEEP_CYC);
        end else if (chg) begin
            beep_cnt <= BW'(BEEP_CYC);
        end else if (beep_cnt != '0) begin
            beep_cnt <= beep_cnt - 1'b1;
        end
    end

    assign beep = |beep_cnt;
`else
    assign beep = BEEP_CYC < 0;
`endif

endmodule

// File: tb/tb_heater_key_ctrl.sv
// Self-checking bench for heater_key_ctrl: vector table, corner sequences,
// and randomized keys against a digit-list reference model.
module tb_heater_key_ctrl;

    localparam int TO   = 100;
    localparam int TMIN = 30;
    localparam int TMAX = 75;
    localparam int TDEF = 40;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic [15:0] pulse;
    logic        power_on;
    logic [1:0]  mode;
    logic [6:0]  setpoint;
    logic        edit_active;
    logic [6:0]  edit_val;
    logic [1:0]  digit_cnt;
    logic        sp_upd;
    logic        err_pulse;
    logic        beep;

    heater_key_ctrl #(
        .T_MIN(TMIN),
        .T_MAX(TMAX),
        .T_DEFAULT(TDEF),
        .TIMEOUT_CYC(TO),
        .CNT_W(28),
        .BEEP_CYC(5)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n(rst_n),
        .pulse(pulse),
        .power_on(power_on),
        .mode(mode),
        .setpoint(setpoint),
        .edit_active(edit_active),
        .edit_val(edit_val),
        .digit_cnt(digit_cnt),
        .sp_upd(sp_upd),
        .err_pulse(err_pulse),
        .beep(beep)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [15:0] p;
        bit          on;
        int          md;
        int          sp;
        bit          ea;
        int          ev;
        int          dc;
        bit          up;
        bit          er;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: entry is kept as a list of decimal digits.
    bit m_on;
    int m_mode;
    int m_sp;
    bit m_edit;
    int m_dig[$];
    int m_idle;
    bit m_upd;
    bit m_err;

    function automatic int m_val();
        int v = 0;
        foreach (m_dig[i]) v = v * 10 + m_dig[i];
        return v;
    endfunction

    task automatic m_reset();
        m_on = 0; m_mode = 0; m_sp = TDEF; m_edit = 0;
        m_dig.delete(); m_idle = 0; m_upd = 0; m_err = 0;
    endtask

    task automatic m_step(input logic [15:0] p);
        int k = -1;
        int v;
        m_upd = 0;
        m_err = 0;
        for (int i = 0; i < 16; i++) if (p[i]) k = i;
        if (!m_on) begin
            if (k == 15) m_on = 1;
        end else if (!m_edit) begin
            case (k)
                15: m_on = 0;
                10: if (m_sp >= TMAX) m_err = 1; else begin m_sp++; m_upd = 1; end
                11: if (m_sp <= TMIN) m_err = 1; else begin m_sp--; m_upd = 1; end
                14: m_mode = (m_mode + 1) % 3;
                default: if (k >= 0 && k <= 9) begin
                    m_edit = 1; m_dig = {k}; m_idle = 0;
                end
            endcase
        end else if (k < 0) begin
            m_idle++;
            if (m_idle == TO) begin m_edit = 0; m_dig.delete(); end
        end else begin
            m_idle = 0;
            v = m_val();
            if (k <= 9) begin
                if (m_dig.size() == 2) m_err = 1; else m_dig.push_back(k);
            end else if (k == 13) begin
                if (m_dig.size() == 0) m_edit = 0;
                else if (v >= TMIN && v <= TMAX) begin
                    m_upd = (v != m_sp); m_sp = v; m_dig.delete(); m_edit = 0;
                end else begin
                    m_err = 1; m_dig.delete();
                end
            end else if (k == 12) begin
                if (m_dig.size() > 0) m_dig.delete(); else m_edit = 0;
            end else if (k == 15) begin
                m_on = 0; m_edit = 0; m_dig.delete();
            end
        end
    endtask

    function automatic vec_t mk(logic [15:0] p, bit on, int md, int sp, bit ea,
                                int ev, int dc, bit up, bit er);
        vec_t v;
        v.p = p; v.on = on; v.md = md; v.sp = sp; v.ea = ea;
        v.ev = ev; v.dc = dc; v.up = up; v.er = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input vec_t e);
        chk({nm, ".power_on"}, 32'(power_on), 32'(e.on));
        chk({nm, ".mode"}, 32'(mode), e.md);
        chk({nm, ".setpoint"}, 32'(setpoint), e.sp);
        chk({nm, ".edit_active"}, 32'(edit_active), 32'(e.ea));
        chk({nm, ".edit_val"}, 32'(edit_val), e.ev);
        chk({nm, ".digit_cnt"}, 32'(digit_cnt), e.dc);
        chk({nm, ".sp_upd"}, 32'(sp_upd), 32'(e.up));
        chk({nm, ".err_pulse"}, 32'(err_pulse), 32'(e.er));
        chk({nm, ".beep"}, 32'(beep), 32'd0);
    endtask

    task automatic check_model(input string nm);
        check_all(nm, mk(16'h0, m_on, m_mode, m_sp, m_edit,
                         m_edit ? m_val() : 0, m_dig.size(), m_upd, m_err));
    endtask

    task automatic tick(input logic [15:0] p);
        pulse = p;
        @(posedge sys_clk);
        if (!rst_n) m_reset(); else m_step(p);
        #1;
        pulse = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(16'h0);
    endtask

    localparam logic [15:0] KA = 16'h0400;
    localparam logic [15:0] KB = 16'h0800;
    localparam logic [15:0] KC = 16'h1000;
    localparam logic [15:0] KD = 16'h2000;
    localparam logic [15:0] KE = 16'h4000;
    localparam logic [15:0] KF = 16'h8000;

    vec_t tbl[$];

    initial begin
        logic [15:0] p;
        int r;

        tbl.push_back(mk(KF,       1, 0, 40, 0,  0, 0, 0, 0));
        tbl.push_back(mk(KE,       1, 1, 40, 0,  0, 0, 0, 0));
        tbl.push_back(mk(KE,       1, 2, 40, 0,  0, 0, 0, 0));
        tbl.push_back(mk(KE,       1, 0, 40, 0,  0, 0, 0, 0));
        tbl.push_back(mk(KA,       1, 0, 41, 0,  0, 0, 1, 0));
        tbl.push_back(mk(KB,       1, 0, 40, 0,  0, 0, 1, 0));
        tbl.push_back(mk(16'h0020, 1, 0, 40, 1,  5, 1, 0, 0));
        tbl.push_back(mk(16'h0020, 1, 0, 40, 1, 55, 2, 0, 0));
        tbl.push_back(mk(KD,       1, 0, 55, 0,  0, 0, 1, 0));
        tbl.push_back(mk(KD,       1, 0, 55, 0,  0, 0, 0, 0));
        tbl.push_back(mk(16'h0200, 1, 0, 55, 1,  9, 1, 0, 0));
        tbl.push_back(mk(16'h0200, 1, 0, 55, 1, 99, 2, 0, 0));
        tbl.push_back(mk(16'h0002, 1, 0, 55, 1, 99, 2, 0, 1));
        tbl.push_back(mk(KD,       1, 0, 55, 1,  0, 0, 0, 1));
        tbl.push_back(mk(KC,       1, 0, 55, 0,  0, 0, 0, 0));
        tbl.push_back(mk(16'h0020, 1, 0, 55, 1,  5, 1, 0, 0));
        tbl.push_back(mk(KA,       1, 0, 55, 1,  5, 1, 0, 0));
        tbl.push_back(mk(KC,       1, 0, 55, 1,  0, 0, 0, 0));
        tbl.push_back(mk(KC,       1, 0, 55, 0,  0, 0, 0, 0));
        tbl.push_back(mk(16'h0020, 1, 0, 55, 1,  5, 1, 0, 0));
        tbl.push_back(mk(16'h0020, 1, 0, 55, 1, 55, 2, 0, 0));
        tbl.push_back(mk(KD,       1, 0, 55, 0,  0, 0, 0, 0));
        tbl.push_back(mk(KE,       1, 1, 55, 0,  0, 0, 0, 0));
        tbl.push_back(mk(16'h8001, 0, 1, 55, 0,  0, 0, 0, 0));
        tbl.push_back(mk(16'h0008, 0, 1, 55, 0,  0, 0, 0, 0));
        tbl.push_back(mk(KA,       0, 1, 55, 0,  0, 0, 0, 0));
        tbl.push_back(mk(KF,       1, 1, 55, 0,  0, 0, 0, 0));
        tbl.push_back(mk(KE,       1, 2, 55, 0,  0, 0, 0, 0));
        tbl.push_back(mk(KE,       1, 0, 55, 0,  0, 0, 0, 0));

        rst_n = 1'b0;
        pulse = '0;
        tick(16'h0);
        tick(16'h0);
        check_all("reset", mk(0, 0, 0, 40, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            tick(tbl[i].p);
            check_all($sformatf("vec%0d", i), tbl[i]);
        end

        for (int s = 56; s <= 74; s++) tick(KA);
        check_all("up74", mk(0, 1, 0, 74, 0, 0, 0, 1, 0));
        tick(KA);
        check_all("up75", mk(0, 1, 0, 75, 0, 0, 0, 1, 0));
        tick(KA);
        check_all("upsat", mk(0, 1, 0, 75, 0, 0, 0, 0, 1));
        tick(16'h0);
        check_all("upsat_1cyc", mk(0, 1, 0, 75, 0, 0, 0, 0, 0));
        for (int s = 74; s >= 30; s--) tick(KB);
        check_all("dn30", mk(0, 1, 0, 30, 0, 0, 0, 1, 0));
        tick(KB);
        check_all("dnsat", mk(0, 1, 0, 30, 0, 0, 0, 0, 1));

        tick(16'h0040);
        idle(TO - 1);
        check_all("to_before", mk(0, 1, 0, 30, 1, 6, 1, 0, 0));
        idle(1);
        check_all("to_expire", mk(0, 1, 0, 30, 0, 0, 0, 0, 0));

        tick(16'h0040);
        idle(TO - 2);
        tick(KA);
        check_all("to_key99", mk(0, 1, 0, 30, 1, 6, 1, 0, 0));
        idle(TO - 1);
        check_all("to_key99_hold", mk(0, 1, 0, 30, 1, 6, 1, 0, 0));
        idle(1);
        check_all("to_key99_exp", mk(0, 1, 0, 30, 0, 0, 0, 0, 0));

        tick(16'h0040);
        idle(TO - 1);
        tick(KA);
        check_all("to_keywins", mk(0, 1, 0, 30, 1, 6, 1, 0, 0));
        idle(TO - 1);
        check_all("to_keywins_hold", mk(0, 1, 0, 30, 1, 6, 1, 0, 0));
        idle(1);
        check_all("to_keywins_exp", mk(0, 1, 0, 30, 0, 0, 0, 0, 0));

        tick(KE);
        tick(16'h0080);
        check_all("pre_rst", mk(0, 1, 1, 30, 1, 7, 1, 0, 0));
        rst_n = 1'b0;
        tick(KF);
        check_all("rst_mid_edit", mk(0, 0, 0, 40, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 399);
            if (r == 0) begin
                rst_n = 1'b0;
                tick(16'(1) << $urandom_range(0, 15));
                rst_n = 1'b1;
                check_model("rnd_rst");
            end else if (r < 4) begin
                for (int j = $urandom_range(TO - 5, TO + 5); j > 0; j--) begin
                    tick(16'h0);
                    check_model("rnd_idle");
                end
            end else begin
                if (r < 200) p = 16'h0;
                else if (r < 370) p = 16'(1) << $urandom_range(0, 15);
                else p = 16'($urandom_range(0, 65535));
                tick(p);
                check_model($sformatf("rnd%0d", n));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/heater_key_ctrl.md
Name: heater_key_ctrl

Overview:
- Consumes the 16 one-hot, single-cycle key pulses from the matrix keyboard scanner and turns them into heater commands: power, mode and temperature setpoint.
- Holds the user-visible control state: power on/off, operating mode, committed setpoint, and an in-progress two-digit numeric entry.
- Feeds the heater driver and the display blocks downstream.

Parameters:
- T_MIN, 30, lowest legal setpoint in °C.
- T_MAX, 75, highest legal setpoint in °C; must be ≤ 99.
- T_DEFAULT, 40, setpoint after reset; must lie within T_MIN..T_MAX.
- TIMEOUT_CYC, 250000000, idle cycles in EDIT before the entry is abandoned (5 s at 50 MHz).
- CNT_W, 28, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.
- BEEP_CYC, 5000000, beep length in cycles; used only with KEY_BEEP_EN.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, synchronous and active-low.
- pulse  in  16  key pulses; bit k set means key k was pressed, one cycle wide.
- power_on  out  1  heater enabled.
- mode  out  2  operating mode: 0 heat, 1 fan, 2 heat+fan.
- setpoint  out  7  committed setpoint in °C, binary.
- edit_active  out  1  high while in EDIT.
- edit_val  out  7  value entered so far, binary.
- digit_cnt  out  2  number of digits entered, 0..2.
- sp_upd  out  1  one-cycle pulse when setpoint changes.
- err_pulse  out  1  one-cycle pulse when a key is rejected.
- beep  out  1  key-acknowledge beeper; tied 0 without KEY_BEEP_EN.

Behaviour:
- Key map:
  - Keys 0–9 are digits.
  - A = up, B = down.
  - C = clear, D = enter.
  - E = mode, F = power.
- Multiple pulse bits in the same cycle: only the highest set index is acted on.
- Latency: every output is registered and changes on the clock edge that samples the pulse (visible the following cycle). sp_upd and err_pulse are high for exactly one cycle.
- Reset values (rst_n low at a clock edge): state OFF, power_on 0, mode 0, setpoint T_DEFAULT, edit_val 0, digit_cnt 0, edit_active 0, sp_upd 0, err_pulse 0, beep 0, timeout counter 0. Reset mid-edit discards the entry.
- States are OFF, RUN and EDIT.
- OFF:
  - F: power_on becomes 1, go to RUN. Setpoint and mode are retained.
  - All other keys: ignored, no err_pulse.
- RUN:
  - F: power_on becomes 0, go to OFF.
  - A: setpoint+1.
  - B: setpoint−1.
  - A/B saturate at T_MAX/T_MIN. A successful step pulses sp_upd. A step at the limit leaves setpoint unchanged and pulses err_pulse instead.
  - E: mode cycles 0→1→2→0.
  - Digit d: go to EDIT with edit_val=d, digit_cnt=1.
  - C, D: ignored.
- EDIT:
  - Digit with digit_cnt=1: edit_val = edit_val×10 + d, digit_cnt=2.
  - Digit with digit_cnt=2: rejected with err_pulse; entry unchanged.
  - D with digit_cnt=0: return to RUN, no change.
  - D with edit_val within T_MIN..T_MAX: setpoint=edit_val, pulse sp_upd only if the value differs, clear the entry, go to RUN.
  - D with edit_val out of range: err_pulse, edit_val=0, digit_cnt=0, stay in EDIT.
  - C with digit_cnt>0: clear the entry and stay in EDIT.
  - C with digit_cnt=0: go to RUN.
  - F: go to OFF and discard the entry.
  - A, B, E: ignored.
- Timeout:
  - The counter resets to 0 on entering EDIT and on every key pulse while in EDIT.
  - When it reaches TIMEOUT_CYC−1 with no key, go to RUN, clear the entry, no err_pulse.
  - A key in that same cycle wins over the timeout.
- edit_active is 1 exactly while in EDIT. edit_val and digit_cnt are 0 outside EDIT.
- The ×10 is computed at 7 bits. The maximum result is 99, so it never overflows.

Optional Feature:
- KEY_BEEP_EN defined:
  - Every key that causes a state or output change loads a down-counter with BEEP_CYC; beep is high while the counter is non-zero.
  - A new accepted key retriggers the counter.
  - A rejected key (err_pulse) loads 3×BEEP_CYC instead.
  - Ignored keys do not beep.
- KEY_BEEP_EN undefined: no beep counter is built; beep is constant 0.

Test Plan:
- Reset, then pulse[15] → power_on=1, setpoint=40, mode=0; pulse[14] twice → mode=2.
- RUN with setpoint=74, pulse[10] twice → setpoint=75 with one sp_upd, then err_pulse with setpoint still 75; from 30, pulse[11] → err_pulse.
- RUN, keys 5, 5, D → edit_active goes high after the first digit, edit_val=55, digit_cnt=2; after D setpoint=55, sp_upd once, edit_active=0.
- EDIT, keys 9, 9, 1, D → third digit gives err_pulse; D gives err_pulse; stays in EDIT with digit_cnt=0; setpoint unchanged.
- EDIT, key 6 then no key for TIMEOUT_CYC cycles (bench overrides to 100) → returns to RUN at cycle 100, edit_val=0; a key at cycle 99 restarts the count.
- Same-cycle pulse=16'h8001 in RUN → power-off wins, power_on=0; rst_n low mid-EDIT → all reset values on the next edge.
